// File: rtl/prog1_pkg.sv
// Shared constants, controller state encoding and the SECDED encode function
// for the program 1 Hamming encoder engine.
package prog1_pkg;

    localparam int NUM_MSGS  = 15;
    localparam int IN_BASE   = 0;
    localparam int OUT_BASE  = 30;
    localparam int MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        WR_LO  = 2'd0,
        WR_HI  = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Encoded word layout: {d[11:5], p8, d[4:2], p4, d1, p2, p1, p0}
    function automatic logic [15:0] hamming_encode(input logic [11:1] d);
        logic p8;
        logic p4;
        logic p2;
        logic p1;
        logic p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/prog1_if.sv
// Data memory bus: two combinational read ports and one synchronous write port.
interface prog1_if;

    logic [7:0] raddr_a_s;
    logic [7:0] raddr_b_s;
    logic [7:0] rdata_a_s;
    logic [7:0] rdata_b_s;
    logic       we_s;
    logic [7:0] waddr_s;
    logic [7:0] wdata_s;

    modport master (
        output raddr_a_s, raddr_b_s, we_s, waddr_s, wdata_s,
        input  rdata_a_s, rdata_b_s
    );

    modport slave (
        input  raddr_a_s, raddr_b_s, we_s, waddr_s, wdata_s,
        output rdata_a_s, rdata_b_s
    );

endinterface

// File: rtl/prog1_datamem.sv
// Byte-wide data memory; contents survive reset so the bench can preload
// inputs and inspect results through myDataMem.memory.
module DataMem
    import prog1_pkg::*;
(
    input logic    clk,
    prog1_if.slave bus
);

    logic [7:0] memory [0:MEM_DEPTH-1];

    assign bus.rdata_a_s = memory[bus.raddr_a_s];
    assign bus.rdata_b_s = memory[bus.raddr_b_s];

    // Single synchronous write port
    always_ff @(posedge clk) begin
        if (bus.we_s) begin
            memory[bus.waddr_s] <= bus.wdata_s;
        end
    end

endmodule

// File: rtl/top_level.sv
// Program 1 engine: walks the fifteen 11-bit messages, writes each SECDED
// codeword as low byte then high byte, and raises done after the last write.
module top_level
    import prog1_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic done
);

    prog1_if mem_bus ();

    state_e     state_r;
    state_e     state_nxt_s;
    logic [3:0] idx_r;
    logic [3:0] idx_nxt_s;
    logic       done_r;
    logic       done_nxt_s;
    logic [7:0] pair_base_s;
    logic [15:0] code_s;
    logic       unused_s;

    DataMem myDataMem (
        .clk (clk),
        .bus (mem_bus.slave)
    );

    assign pair_base_s       = {3'b000, idx_r, 1'b0};
    assign mem_bus.raddr_a_s = pair_base_s + 8'(IN_BASE);
    assign mem_bus.raddr_b_s = pair_base_s + 8'(IN_BASE + 1);
    // Upper five bits of each odd input byte are not part of the message
    assign code_s            = hamming_encode({mem_bus.rdata_b_s[2:0], mem_bus.rdata_a_s});
    assign unused_s          = ^mem_bus.rdata_b_s[7:3];
    assign done              = done_r;

    // Next-state, counter and write-port control
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        done_nxt_s      = done_r;
        mem_bus.we_s    = 1'b0;
        mem_bus.waddr_s = pair_base_s + 8'(OUT_BASE);
        mem_bus.wdata_s = code_s[7:0];
        if (reset) begin
            mem_bus.we_s = 1'b0;
        end else begin
            case (state_r)
                WR_LO: begin
                    mem_bus.we_s = 1'b1;
                    state_nxt_s  = WR_HI;
                end
                WR_HI: begin
                    mem_bus.we_s    = 1'b1;
                    mem_bus.waddr_s = pair_base_s + 8'(OUT_BASE + 1);
                    mem_bus.wdata_s = code_s[15:8];
                    if (idx_r == 4'(NUM_MSGS - 1)) begin
                        state_nxt_s = FINISH;
                        done_nxt_s  = 1'b1;
                    end else begin
                        idx_nxt_s   = idx_r + 4'd1;
                        state_nxt_s = WR_LO;
                    end
                end
                FINISH: begin
                    done_nxt_s = 1'b1;
                end
                default: begin
                    state_nxt_s = WR_LO;
                    idx_nxt_s   = 4'd0;
                    done_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // Controller state registers with synchronous restart
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= WR_LO;
            idx_r   <= 4'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for the program 1 SECDED encoder: expected bytes are queued
// at preload time and popped as each output byte is written.
module tb_top_level;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic done;

    always #5 clk = ~clk;

    top_level dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    typedef struct {
        int         addr;
        logic [7:0] val;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] in_img [0:29];

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Classic positional Hamming(15,11) plus overall parity in bit 0
    function automatic logic [15:0] ref_code(input logic [10:0] m);
        logic [15:0] w;
        int dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        w = 16'h0000;
        for (int b = 0; b < 11; b++) w[dpos[b]] = m[b];
        for (int k = 1; k < 16; k = k * 2) begin
            logic p;
            p = 1'b0;
            for (int j = 1; j < 16; j++) if ((j & k) != 0) p = p ^ w[j];
            w[k] = p;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    // Load inputs, poison outputs with the inverse of the expected value, queue expectations
    task automatic prepare();
        logic [15:0] c;
        for (int a = 0; a < 30; a++) dut.myDataMem.memory[a] = in_img[a];
        for (int a = 60; a < 64; a++) dut.myDataMem.memory[a] = 8'h5A;
        for (int i = 0; i < 15; i++) begin
            exp_t e;
            c = ref_code({in_img[2*i+1][2:0], in_img[2*i]});
            e.addr = 30 + 2*i; e.val = c[7:0];
            sb_q.push_back(e);
            dut.myDataMem.memory[e.addr] = ~c[7:0];
            e.addr = 31 + 2*i; e.val = c[15:8];
            sb_q.push_back(e);
            dut.myDataMem.memory[e.addr] = ~c[15:8];
        end
    endtask

    task automatic start_run();
        reset = 1'b1;
        @(posedge clk);
        #1;
        prepare();
        check_val("done_in_reset", {15'd0, done}, 16'd0);
        reset = 1'b0;
    endtask

    task automatic run_edges(input int first, input int last);
        exp_t e;
        for (int k = first; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check_val("sb_underrun", 16'd1, 16'd0);
            end else begin
                e = sb_q.pop_front();
                check_val($sformatf("byte%0d_edge%0d", e.addr, k),
                          {8'd0, dut.myDataMem.memory[e.addr]}, {8'd0, e.val});
            end
            check_val($sformatf("done_edge%0d", k), {15'd0, done}, {15'd0, (k >= 30)});
        end
    endtask

    task automatic finish_checks();
        repeat (3) @(posedge clk);
        #1;
        check_val("done_held", {15'd0, done}, 16'd1);
        check_val("sb_empty", 16'(sb_q.size()), 16'd0);
        for (int a = 0; a < 30; a++)
            check_val($sformatf("input%0d", a), {8'd0, dut.myDataMem.memory[a]}, {8'd0, in_img[a]});
        for (int a = 60; a < 64; a++)
            check_val($sformatf("untouched%0d", a), {8'd0, dut.myDataMem.memory[a]}, 16'h005A);
    endtask

    initial begin
        logic [7:0] pv;

        // All-zero messages
        for (int a = 0; a < 30; a++) in_img[a] = 8'h00;
        start_run();
        run_edges(1, 30);
        finish_checks();

        // Directed corner messages, garbage in ignored high bits of message 14
        for (int a = 0; a < 30; a++) in_img[a] = 8'h00;
        in_img[0]  = 8'hFF; in_img[1]  = 8'h07;
        in_img[2]  = 8'h01; in_img[3]  = 8'h00;
        in_img[28] = 8'h00; in_img[29] = 8'hFC;
        start_run();
        run_edges(1, 30);
        finish_checks();
        check_val("k_m0_hi", {8'd0, dut.myDataMem.memory[31]}, 16'h00FF);
        check_val("k_m0_lo", {8'd0, dut.myDataMem.memory[30]}, 16'h00FF);
        check_val("k_m1_hi", {8'd0, dut.myDataMem.memory[33]}, 16'h0000);
        check_val("k_m1_lo", {8'd0, dut.myDataMem.memory[32]}, 16'h000F);
        check_val("k_m14_hi", {8'd0, dut.myDataMem.memory[59]}, 16'h0081);
        check_val("k_m14_lo", {8'd0, dut.myDataMem.memory[58]}, 16'h0017);

        // Random messages with random ignored bits
        for (int a = 0; a < 30; a++) in_img[a] = 8'($urandom_range(0, 255));
        start_run();
        run_edges(1, 30);
        finish_checks();

        // Restart mid-run after edge 12
        for (int a = 0; a < 30; a++) in_img[a] = 8'($urandom_range(0, 255));
        start_run();
        run_edges(1, 12);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("done_restart", {15'd0, done}, 16'd0);
        pv = ~sb_q[0].val;
        check_val("no_write_in_reset", {8'd0, dut.myDataMem.memory[42]}, {8'd0, pv});
        sb_q.delete();
        prepare();
        reset = 1'b0;
        run_edges(1, 30);
        finish_checks();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
